// File: rtl/router_pkt_reg.sv
// Packet datapath register for the 1xN router.
// Captures the header, forwards bytes to the FIFO, holds a stalled byte,
// counts payload, accumulates parity and flags parity, length and address errors.
module router_pkt_reg #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 2,
    parameter int unsigned N_CH       = 3,
    parameter bit          PARITY_INV = 1'b0
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     pkt_valid,
    input  logic                     fifo_full,
    input  logic                     detect_add,
    input  logic                     lfd_state,
    input  logic                     ld_state,
    input  logic                     laf_state,
    input  logic                     full_state,
    input  logic                     rst_int_reg,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_valid,
    output logic [ADDR_W-1:0]        hdr_addr,
    output logic                     addr_err,
    output logic [DATA_W-ADDR_W-1:0] byte_cnt,
    output logic                     parity_done,
    output logic                     low_pkt_valid,
    output logic                     chk_valid,
    output logic                     err,
    output logic                     len_err
);

    localparam int unsigned        CNT_W    = DATA_W - ADDR_W;
    localparam int unsigned        AW1      = ADDR_W + 1;
    localparam logic [AW1-1:0]     N_CH_V   = AW1'(N_CH);
    localparam logic [DATA_W-1:0]  PAR_SEED = {DATA_W{PARITY_INV}};

    logic [DATA_W-1:0] header_q,     header_d;
    logic              addr_err_q,   addr_err_d;
    logic [DATA_W-1:0] dout_q,       dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic [DATA_W-1:0] hold_q,       hold_d;
    logic              hold_pay_q,   hold_pay_d;
    logic [DATA_W-1:0] parity_q,     parity_d;
    logic [DATA_W-1:0] pkt_par_q,    pkt_par_d;
    logic [CNT_W-1:0]  byte_cnt_q,   byte_cnt_d;
    logic              cnt_ovf_q,    cnt_ovf_d;
    logic              par_done_q,   par_done_d;
    logic              done_seen_q,  done_seen_d;
    logic              low_pv_q,     low_pv_d;
    logic              chk_valid_q,  chk_valid_d;
    logic              err_q,        err_d;
    logic              len_err_q,    len_err_d;

    logic              take;
    logic [DATA_W-1:0] take_data;
    logic              take_pay;

    // Next-state datapath: header capture, byte loading, accounting and check.
    always_comb begin
        header_d     = header_q;
        addr_err_d   = addr_err_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        hold_d       = hold_q;
        hold_pay_d   = hold_pay_q;
        parity_d     = parity_q;
        pkt_par_d    = pkt_par_q;
        byte_cnt_d   = byte_cnt_q;
        cnt_ovf_d    = cnt_ovf_q;
        par_done_d   = par_done_q;
        done_seen_d  = done_seen_q;
        chk_valid_d  = 1'b0;
        err_d        = err_q;
        len_err_d    = len_err_q;
        take         = 1'b0;
        take_data    = data_in;
        take_pay     = 1'b0;

        if (detect_add && pkt_valid) begin
            header_d    = data_in;
            addr_err_d  = ({1'b0, data_in[ADDR_W-1:0]} >= N_CH_V);
            hold_pay_d  = 1'b0;
            parity_d    = PAR_SEED;
            byte_cnt_d  = '0;
            cnt_ovf_d   = 1'b0;
            par_done_d  = 1'b0;
            done_seen_d = 1'b0;
            err_d       = 1'b0;
            len_err_d   = 1'b0;
        end else begin
            if (lfd_state && !full_state) begin
                dout_d       = header_q;
                dout_valid_d = 1'b1;
                parity_d     = parity_q ^ header_q;
            end else if (ld_state && !fifo_full) begin
                dout_d       = data_in;
                dout_valid_d = 1'b1;
                take         = 1'b1;
                take_data    = data_in;
                take_pay     = pkt_valid;
            end else if (ld_state && fifo_full) begin
                hold_d     = data_in;
                hold_pay_d = pkt_valid;
            end else if (laf_state) begin
                dout_d       = hold_q;
                dout_valid_d = 1'b1;
                take         = 1'b1;
                take_data    = hold_q;
                take_pay     = hold_pay_q;
            end

            // Direct load and held-byte replay share one accounting path.
            if (take) begin
                if (take_pay) begin
                    parity_d = parity_q ^ take_data;
                    if (&byte_cnt_q) cnt_ovf_d  = 1'b1;
                    else             byte_cnt_d = byte_cnt_q + CNT_W'(1);
                end else if (!par_done_q) begin
                    pkt_par_d  = take_data;
                    par_done_d = 1'b1;
                end
            end

            // Check fires once, on the first cycle parity_done is seen high.
            done_seen_d = par_done_q;
            chk_valid_d = par_done_q && !done_seen_q;
            if (chk_valid_d) begin
                err_d     = (parity_q != pkt_par_q);
                len_err_d = (byte_cnt_q != header_q[DATA_W-1:ADDR_W]) || cnt_ovf_q;
            end
        end

        if (rst_int_reg || detect_add)          low_pv_d = 1'b0;
        else if (ld_state && !pkt_valid)        low_pv_d = 1'b1;
        else                                    low_pv_d = low_pv_q;
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            header_q     <= '0;
            addr_err_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            hold_q       <= '0;
            hold_pay_q   <= 1'b0;
            parity_q     <= PAR_SEED;
            pkt_par_q    <= '0;
            byte_cnt_q   <= '0;
            cnt_ovf_q    <= 1'b0;
            par_done_q   <= 1'b0;
            done_seen_q  <= 1'b0;
            low_pv_q     <= 1'b0;
            chk_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            header_q     <= header_d;
            addr_err_q   <= addr_err_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            hold_q       <= hold_d;
            hold_pay_q   <= hold_pay_d;
            parity_q     <= parity_d;
            pkt_par_q    <= pkt_par_d;
            byte_cnt_q   <= byte_cnt_d;
            cnt_ovf_q    <= cnt_ovf_d;
            par_done_q   <= par_done_d;
            done_seen_q  <= done_seen_d;
            low_pv_q     <= low_pv_d;
            chk_valid_q  <= chk_valid_d;
            err_q        <= err_d;
            len_err_q    <= len_err_d;
        end
    end

    assign dout          = dout_q;
    assign dout_valid    = dout_valid_q;
    assign hdr_addr      = header_q[ADDR_W-1:0];
    assign addr_err      = addr_err_q;
    assign byte_cnt      = byte_cnt_q;
    assign parity_done   = par_done_q;
    assign low_pkt_valid = low_pv_q;
    assign chk_valid     = chk_valid_q;
    assign err           = err_q;
    assign len_err       = len_err_q;

endmodule

// File: tb/tb_router_pkt_reg.sv
// Bench for router_pkt_reg: one default instance (8b XOR) and one wide
// instance (16b, 3-bit address, 5 channels, XNOR) driven by shared strobes.
module tb_router_pkt_reg;

    logic clk = 1'b0;
    logic resetn;
    logic pkt_valid, fifo_full, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic [7:0]  da;
    logic [15:0] db;

    logic [7:0]  a_dout;  logic a_dv; logic [1:0] a_hdr; logic a_aerr; logic [5:0]  a_cnt;
    logic a_pd, a_lpv, a_chk, a_err, a_lerr;
    logic [15:0] b_dout;  logic b_dv; logic [2:0] b_hdr; logic b_aerr; logic [12:0] b_cnt;
    logic b_pd, b_lpv, b_chk, b_err, b_lerr;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0]  pa[$];
    logic [15:0] pb[$];
    logic last_err_a, last_err_b;

    always #5 clk = ~clk;

    router_pkt_reg u_a (
        .clk(clk), .resetn(resetn), .data_in(da), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .rst_int_reg(rst_int_reg), .dout(a_dout), .dout_valid(a_dv),
        .hdr_addr(a_hdr), .addr_err(a_aerr), .byte_cnt(a_cnt), .parity_done(a_pd),
        .low_pkt_valid(a_lpv), .chk_valid(a_chk), .err(a_err), .len_err(a_lerr)
    );

    router_pkt_reg #(.DATA_W(16), .ADDR_W(3), .N_CH(5), .PARITY_INV(1'b1)) u_b (
        .clk(clk), .resetn(resetn), .data_in(db), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .rst_int_reg(rst_int_reg), .dout(b_dout), .dout_valid(b_dv),
        .hdr_addr(b_hdr), .addr_err(b_aerr), .byte_cnt(b_cnt), .parity_done(b_pd),
        .low_pkt_valid(b_lpv), .chk_valid(b_chk), .err(b_err), .len_err(b_lerr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pkt_valid = 1'b0; fifo_full = 1'b0; detect_add = 1'b0; lfd_state = 1'b0;
        ld_state = 1'b0; laf_state = 1'b0; full_state = 1'b0; rst_int_reg = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a_dout"}, a_dout, 0); chk({tag, "_a_dv"}, a_dv, 0);
        chk({tag, "_a_hdr"}, a_hdr, 0);   chk({tag, "_a_cnt"}, a_cnt, 0);
        chk({tag, "_a_flags"}, {a_aerr, a_pd, a_lpv, a_chk, a_err, a_lerr}, 0);
        chk({tag, "_b_dout"}, b_dout, 0); chk({tag, "_b_dv"}, b_dv, 0);
        chk({tag, "_b_hdr"}, b_hdr, 0);   chk({tag, "_b_cnt"}, b_cnt, 0);
        chk({tag, "_b_flags"}, {b_aerr, b_pd, b_lpv, b_chk, b_err, b_lerr}, 0);
    endtask

    task automatic fill_rand(input int n);
        pa.delete(); pb.delete();
        for (int i = 0; i < n; i++) begin
            pa.push_back(8'($urandom));
            pb.push_back(16'($urandom));
        end
    endtask

    // Full packet through both instances; payload comes from pa/pb.
    // stall_at selects the byte (payload index, or n for parity) that meets a full FIFO.
    task automatic do_pkt(input logic [7:0] ha, input logic [15:0] hb, input int stall_at,
                          input logic [7:0] bad_a, input logic [15:0] bad_b);
        int          n;
        logic [7:0]  xor_a, par_a, xa;
        logic [15:0] xor_b, par_b, xb;
        int          cnt_a;
        bit          lerr_a, lerr_b;
        n = pa.size();

        idle_inputs();
        detect_add = 1'b1; pkt_valid = 1'b1; da = ha; db = hb;
        tick();
        chk("hdr_addr_a", a_hdr, ha[1:0]);
        chk("addr_err_a", a_aerr, int'(ha[1:0]) >= 3);
        chk("hdr_addr_b", b_hdr, hb[2:0]);
        chk("addr_err_b", b_aerr, int'(hb[2:0]) >= 5);
        chk("hdr_clr_a", {a_cnt, a_pd, a_lpv, a_chk, a_err, a_lerr, a_dv}, 0);
        chk("hdr_clr_b", {b_cnt, b_pd, b_lpv, b_chk, b_err, b_lerr, b_dv}, 0);

        detect_add = 1'b0; lfd_state = 1'b1;
        tick();
        chk("lfd_dout_a", {a_dv, a_dout}, {1'b1, ha});
        chk("lfd_dout_b", {b_dv, b_dout}, {1'b1, hb});
        lfd_state = 1'b0;

        // Parity of a packet: XOR of header and payload, inverted for the XNOR instance.
        xor_a = ha; xor_b = hb;
        foreach (pa[i]) xor_a ^= pa[i];
        foreach (pb[i]) xor_b ^= pb[i];
        par_a = xor_a ^ bad_a;
        par_b = ~xor_b ^ bad_b;

        for (int i = 0; i <= n; i++) begin
            xa = (i < n) ? pa[i] : par_a;
            xb = (i < n) ? pb[i] : par_b;
            ld_state = 1'b1; pkt_valid = (i < n); da = xa; db = xb;
            if (i == stall_at) begin
                fifo_full = 1'b1;
                tick();
                chk("stall_dv", {a_dv, b_dv}, 0);
                fifo_full = 1'b0; ld_state = 1'b0; laf_state = 1'b1; full_state = 1'b1;
                da = 8'($urandom); db = 16'($urandom);
                tick();
                laf_state = 1'b0; full_state = 1'b0;
            end else begin
                tick();
            end
            chk("ld_dout_a", {a_dv, a_dout}, {1'b1, xa});
            chk("ld_dout_b", {b_dv, b_dout}, {1'b1, xb});
        end
        ld_state = 1'b0; pkt_valid = 1'b0;
        chk("pdone_lpv", {a_pd, a_lpv, b_pd, b_lpv}, 4'hF);

        tick();
        cnt_a  = (n > 63) ? 63 : n;
        lerr_a = (n > 63) || (cnt_a != int'(ha[7:2]));
        lerr_b = (n != int'(hb[15:3]));
        chk("chk_pulse", {a_chk, b_chk, a_dv, b_dv}, 4'b1100);
        chk("err_a", a_err, bad_a != 0);
        chk("err_b", b_err, bad_b != 0);
        chk("len_err_a", a_lerr, lerr_a);
        chk("len_err_b", b_lerr, lerr_b);
        chk("byte_cnt_a", a_cnt, cnt_a);
        chk("byte_cnt_b", b_cnt, n);

        tick();
        chk("chk_one_cycle", {a_chk, b_chk}, 0);
        chk("err_hold", {a_err, b_err}, {bad_a != 0, bad_b != 0});
        last_err_a = (bad_a != 0);
        last_err_b = (bad_b != 0);
    endtask

    initial begin
        logic [7:0]  x8;
        logic [15:0] x16;
        int          n, s;

        idle_inputs();
        da = '0; db = '0;
        resetn = 1'b0;
        #1;
        check_all_zero("reset");
        tick(); tick();
        resetn = 1'b1;
        tick();

        // Directed clean packet, then the same packet with a corrupted parity byte.
        pa = {8'h11, 8'h22, 8'h33};
        pb = {16'h1234, 16'h8001, 16'hBEEF};
        do_pkt(8'h0D, {13'd3, 3'd1}, -1, 8'h00, 16'h0000);
        do_pkt(8'h0D, {13'd3, 3'd1}, -1, 8'h11, 16'h0001);

        // A second parity byte is ignored; set and clear of low_pkt_valid together clears.
        ld_state = 1'b1; pkt_valid = 1'b0; rst_int_reg = 1'b1;
        x8 = 8'($urandom); x16 = 16'($urandom); da = x8; db = x16;
        tick();
        chk("lpv_set_clr", {a_lpv, b_lpv}, 0);
        chk("par2_dout", {a_dout, b_dout}, {x8, x16});
        chk("par2_pdone", {a_pd, b_pd}, 2'b11);
        idle_inputs();
        tick();
        chk("par2_no_chk", {a_chk, b_chk}, 0);
        chk("par2_err_keep", {a_err, b_err}, {last_err_a, last_err_b});
        tick();
        chk("par2_no_chk_late", {a_chk, b_chk}, 0);

        // Short packet: length field says 3, only 2 payload bytes arrive.
        pa = {8'h11, 8'h22};
        pb = {16'h0F0F, 16'h7777};
        do_pkt(8'h0D, {13'd3, 3'd2}, -1, 8'h00, 16'h0000);

        // FIFO full on the second payload byte, replayed through laf_state.
        pa = {8'h11, 8'h22, 8'h33};
        pb = {16'hAAAA, 16'h5555, 16'h0102};
        do_pkt(8'h0D, {13'd3, 3'd4}, 1, 8'h00, 16'h0000);
        fill_rand(2);
        do_pkt({6'd2, 2'd2}, {13'd2, 3'd3}, 2, 8'h00, 16'h0000);

        // Invalid then valid addresses.
        fill_rand(0);
        do_pkt(8'h03, {13'd0, 3'd5}, -1, 8'h00, 16'h0000);
        fill_rand(1);
        do_pkt(8'h04, {13'd1, 3'd4}, -1, 8'h00, 16'h0000);
        fill_rand(0);
        do_pkt(8'h02, {13'd0, 3'd7}, -1, 8'h00, 16'h0000);

        // Reset in the middle of a packet clears everything immediately.
        idle_inputs();
        detect_add = 1'b1; pkt_valid = 1'b1; da = 8'h0D; db = {13'd3, 3'd2};
        tick();
        detect_add = 1'b0; lfd_state = 1'b1;
        tick();
        lfd_state = 1'b0; ld_state = 1'b1; da = 8'h11; db = 16'h4321;
        tick();
        da = 8'h22; db = 16'h9876;
        tick();
        idle_inputs();
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("midpkt_reset");
        tick();
        resetn = 1'b1;
        pa = {8'h11, 8'h22, 8'h33};
        pb = {16'h0001, 16'h0002, 16'h0003};
        do_pkt(8'h0D, {13'd3, 3'd1}, -1, 8'h00, 16'h0000);

        // Counter boundary: exactly all-ones, then one increment past it.
        fill_rand(63);
        do_pkt(8'hFD, {13'd63, 3'd0}, -1, 8'h00, 16'h0000);
        fill_rand(64);
        do_pkt(8'hFE, {13'd64, 3'd1}, 10, 8'h00, 16'h0000);

        // Random packets.
        for (int k = 0; k < 12; k++) begin
            n = $urandom_range(0, 6);
            s = $urandom_range(0, n + 3);
            if (s > n) s = -1;
            fill_rand(n);
            x8  = 8'($urandom);
            x16 = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                x8[7:2]   = 6'(n);
                x16[15:3] = 13'(n);
            end
            do_pkt(x8, x16, s,
                   ($urandom_range(0, 1) == 1) ? 8'h00 : (8'($urandom) | 8'h01),
                   ($urandom_range(0, 1) == 1) ? 16'h0000 : (16'($urandom) | 16'h0100));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
